ob_ram_write_arbiter: RTL and testbench
=======================================

// Module: ob_ram_write_arbiter
// PURPOSE
//  Shares one order-book RAM write port between N_BOOKS per-book snapshot writers.
//  Each writer requests, receives a grant for a whole burst (up to 10 asks + 10 bids),
//  and streams slot-indexed 128-bit entries until it flags the last beat.
//  The arbiter maps (book, slot) to a flat RAM address and registers the port outputs.
//  Grants rotate round-robin so no book starves.
// PARAMETERS
//  N_BOOKS      4    number of requesting order-book writers
//  DATA_W       128  RAM word width (one order entry incl. valid bit and padding)
//  SLOT_W       5    width of per-book slot index
//  BOOK_SLOTS   20   slots per book; asks occupy 0..9, bids 10..19
//  ADDR_W       10   RAM address width; must satisfy N_BOOKS*BOOK_SLOTS <= 2**ADDR_W
//  TIMEOUT_CYC  64   idle-beat limit while granted (used only with OB_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1                 clock
//  rst         in   1                 synchronous reset, active-high
//  req         in   N_BOOKS           writer i requests the RAM port; held until granted
//  wr_en       in   N_BOOKS           writer i presents a beat this cycle
//  wr_last     in   N_BOOKS           beat is the final one of writer i's burst
//  wr_slot     in   N_BOOKS*SLOT_W    slot index per writer (packed, writer 0 in LSBs)
//  wr_data     in   N_BOOKS*DATA_W    entry data per writer (packed, writer 0 in LSBs)
//  grant       out  N_BOOKS           one-hot; writer i owns the port
//  ram_wren    out  1                 RAM write enable
//  ram_addr    out  ADDR_W            book*BOOK_SLOTS + slot
//  ram_data    out  DATA_W            registered copy of granted writer's data
//  busy        out  1                 high while any grant is held
//  slot_err    out  1                 1-cycle pulse: granted beat had slot >= BOOK_SLOTS
//  timeout     out  1                 1-cycle pulse: grant revoked by timeout (0 if macro off)
// BEHAVIOUR
//  Reset: grant=0, ram_wren=0, ram_addr=0, ram_data=0, busy=0, slot_err=0, timeout=0,
//   rr pointer=0, state=IDLE. Reset mid-burst drops the grant; no further RAM writes.
//  States: IDLE -> GRANTED (any req seen) -> IDLE (last beat, req drop, or timeout).
//  IDLE: pick first set req at or after rr pointer, wrapping; grant is registered,
//   so it asserts the cycle after req is sampled. busy mirrors |grant.
//  GRANTED: only the granted writer's wr_en/wr_last/wr_slot/wr_data are sampled.
//   Other writers' wr_en are ignored and must not write.
//  Beat latency: wr_en at cycle t -> ram_wren/addr/data valid at t+1, for exactly 1 cycle.
//  Address: book_idx*BOOK_SLOTS + slot, computed at ADDR_W bits; no wrap-around.
//  slot >= BOOK_SLOTS: write suppressed (ram_wren=0), slot_err pulses at t+1, burst continues.
//  wr_en & wr_last: beat is written; grant drops at t+1; rr pointer = granted+1 mod N_BOOKS.
//   IDLE rearbitrates at t+1 and the next grant asserts at t+2 (one bubble cycle).
//  req deasserted while granted without last: treated as burst end, same pointer update.
//  wr_last without wr_en is ignored. Simultaneous requests are resolved by rr order only.
// CONFIGURATION
//  OB_ARB_TIMEOUT_EN defined: counter clears on each granted beat.
//   TIMEOUT_CYC consecutive granted cycles with no wr_en -> grant revoked, timeout
//   pulses 1 cycle, pointer advances as for last.
//  Undefined: no counter; grant held until last or req drop; timeout tied 0.
// STRUCTURE
//  ob_ram_pkg: N_BOOKS/BOOK_SLOTS/ASK_BASE=0/BID_BASE=10 constants, arb_state_e enum,
//   ob_entry_t (DATA_W packed entry: valid, pad, 89-bit order).
//  Sub-module rr_priority_picker: combinational round-robin pick (req, ptr -> onehot, idx).
// TESTING
//  1. Book1 req, 20 beats slots 0..19, last on 19 -> addrs 20..39, grant drops next cycle.
//  2. req=4'b0101 in IDLE, ptr 0 -> book0 first; after its last, book2 granted 2 cycles later.
//  3. All 4 books req continuously, 1-beat bursts -> grant order 0,1,2,3,0; no book skipped.
//  4. Granted book3 sends slot 25 -> no ram_wren, slot_err=1 for 1 cycle; next slot 5 -> addr 65.
//  5. rst high mid-burst at beat 7 -> grant=0, ram_wren=0 next cycle; after release, ptr 0 wins.
//  6. Macro on, TIMEOUT_CYC=64: granted, 64 idle cycles -> timeout pulse, grant moves to next req.

Source files
------------

// File: rtl/ob_ram_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ob_ram_write_arbiter_pkg
// Purpose : Shared constants and types for the order-book RAM write arbiter.
//           Provides the default geometry (books, slots, widths), the ask/bid
//           slot bases, the arbiter state enum and the packed order entry.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ob_ram_write_arbiter_pkg;

  localparam int ARB_N_BOOKS     = 4;
  localparam int ARB_DATA_W      = 128;
  localparam int ARB_SLOT_W      = 5;
  localparam int ARB_BOOK_SLOTS  = 20;
  localparam int ARB_ADDR_W      = 10;
  localparam int ARB_TIMEOUT_CYC = 64;

  // Within a book, asks occupy slots 0..9 and bids occupy slots 10..19.
  localparam int ASK_BASE = 0;
  localparam int BID_BASE = 10;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // One RAM word: valid flag, padding, 89-bit order payload.
  typedef struct packed {
    logic        valid;
    logic [37:0] pad;
    logic [88:0] order;
  } ob_entry_t;

endpackage
`default_nettype wire

// File: rtl/ob_ram_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ob_ram_write_arbiter_if
// Purpose : Bundles the per-book writer handshake and the RAM write port.
// Ports   : master modport (writer/RAM side) drives req, wr_en, wr_last,
//           wr_slot, wr_data and observes grant, ram_wren, ram_addr,
//           ram_data, busy, slot_err, timeout.
//           slave modport (arbiter) is the mirror image.
//           Packed per-writer buses carry writer 0 in the LSBs.
// Revision: 1.0 - initial release
// ============================================================================
interface ob_ram_write_arbiter_if
  import ob_ram_write_arbiter_pkg::*;
#(
  parameter int N_BOOKS = ARB_N_BOOKS,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int SLOT_W  = ARB_SLOT_W,
  parameter int ADDR_W  = ARB_ADDR_W
);

  logic [N_BOOKS-1:0]        req;
  logic [N_BOOKS-1:0]        wr_en;
  logic [N_BOOKS-1:0]        wr_last;
  logic [N_BOOKS*SLOT_W-1:0] wr_slot;
  logic [N_BOOKS*DATA_W-1:0] wr_data;

  logic [N_BOOKS-1:0]        grant;
  logic                      ram_wren;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data;
  logic                      busy;
  logic                      slot_err;
  logic                      timeout;

  modport master (
    output req, wr_en, wr_last, wr_slot, wr_data,
    input  grant, ram_wren, ram_addr, ram_data, busy, slot_err, timeout
  );

  modport slave (
    input  req, wr_en, wr_last, wr_slot, wr_data,
    output grant, ram_wren, ram_addr, ram_data, busy, slot_err, timeout
  );

endinterface
`default_nettype wire

// File: rtl/ob_ram_write_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_picker
// Purpose : Combinational round-robin selection. Returns the first set
//           request at or after ptr, wrapping past N-1 back to 0.
// Ports   : req    in  N      request vector
//           ptr    in  IDX_W  highest-priority index
//           onehot out N      one-hot winner (0 when no request)
//           idx    out IDX_W  binary winner index
//           valid  out 1      any request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    onehot   = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        onehot           = '0;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
        valid            = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ob_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ob_ram_write_arbiter
// Purpose : Shares one order-book RAM write port between N_BOOKS snapshot
//           writers. A writer holds the port for a whole burst; beats are
//           mapped to book*BOOK_SLOTS + slot and registered onto the port.
//           Grants rotate round-robin.
// Ports   : clk  in  clock
//           rst  in  synchronous reset, active-high
//           bus  ob_ram_write_arbiter_if.slave (writer handshake + RAM port)
// Config  : OB_ARB_TIMEOUT_EN - when defined, a grant idle for TIMEOUT_CYC
//           consecutive cycles is revoked and timeout pulses; otherwise
//           timeout is tied low and grants end only on last beat/req drop.
// Revision: 1.0 - initial release
// ============================================================================
module ob_ram_write_arbiter
  import ob_ram_write_arbiter_pkg::*;
#(
  parameter int N_BOOKS     = ARB_N_BOOKS,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int SLOT_W      = ARB_SLOT_W,
  parameter int BOOK_SLOTS  = ARB_BOOK_SLOTS,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input logic                   clk,
  input logic                   rst,
  ob_ram_write_arbiter_if.slave bus
);

  localparam int IDX_W = (N_BOOKS > 1) ? $clog2(N_BOOKS) : 1;

  localparam logic [0:0] ST_IDLE    = ARB_IDLE;
  localparam logic [0:0] ST_GRANTED = ARB_GRANTED;

  if ((N_BOOKS * BOOK_SLOTS > 2 ** ADDR_W) || (TIMEOUT_CYC < 1)) begin : g_bad_params
    $error("ob_ram_write_arbiter: address space too small or TIMEOUT_CYC < 1");
  end

  logic [0:0]        state;
  logic [N_BOOKS-1:0] grant_r;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  ptr;
  logic              ram_wren_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_data_r;
  logic              slot_err_r;
  logic              timeout_r;

  logic [N_BOOKS-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic              sel_req;
  logic              sel_en;
  logic              sel_last;
  logic [SLOT_W-1:0] sel_slot;
  logic [DATA_W-1:0] sel_data;
  logic              slot_ok;
  logic [ADDR_W-1:0] beat_addr;
  logic [IDX_W-1:0]  ptr_after;
  logic              burst_end;
  logic              tmo_hit;

  rr_priority_picker #(
    .N     (N_BOOKS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Only the owner's lane is looked at; other writers cannot reach the port.
  always_comb begin
    sel_req  = 1'b0;
    sel_en   = 1'b0;
    sel_last = 1'b0;
    sel_slot = '0;
    sel_data = '0;
    for (int b = 0; b < N_BOOKS; b++) begin
      if (owner == IDX_W'(b)) begin
        sel_req  = bus.req[b];
        sel_en   = bus.wr_en[b];
        sel_last = bus.wr_last[b];
        sel_slot = bus.wr_slot[b*SLOT_W +: SLOT_W];
        sel_data = bus.wr_data[b*DATA_W +: DATA_W];
      end
    end
  end

  assign slot_ok   = (32'(sel_slot) < BOOK_SLOTS);
  assign beat_addr = ADDR_W'(owner) * ADDR_W'(BOOK_SLOTS) + ADDR_W'(sel_slot);
  assign ptr_after = (owner == IDX_W'(N_BOOKS - 1)) ? '0 : owner + 1'b1;

`ifdef OB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Counts consecutive owned cycles without a beat; restarts on every beat
  // and whenever the port is not owned.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_GRANTED) || sel_en) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ST_GRANTED) && !sel_en &&
                   (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // A burst ends on a written last beat, on the owner dropping req, or on
  // timeout; all three hand priority to the next book in ring order.
  assign burst_end = (sel_en && sel_last) || !sel_req || tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_r    <= '0;
      owner      <= '0;
      ptr        <= '0;
      ram_wren_r <= 1'b0;
      ram_addr_r <= '0;
      ram_data_r <= '0;
      slot_err_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      ram_wren_r <= 1'b0;
      slot_err_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_r <= pick_onehot;
            owner   <= pick_idx;
            state   <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (sel_en) begin
            if (slot_ok) begin
              ram_wren_r <= 1'b1;
              ram_addr_r <= beat_addr;
              ram_data_r <= sel_data;
            end else begin
              slot_err_r <= 1'b1;
            end
          end
          if (burst_end) begin
            grant_r   <= '0;
            ptr       <= ptr_after;
            state     <= ST_IDLE;
            timeout_r <= tmo_hit;
          end
        end
        default: begin
          grant_r <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = grant_r;
  assign bus.busy     = |grant_r;
  assign bus.ram_wren = ram_wren_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_data = ram_data_r;
  assign bus.slot_err = slot_err_r;
  assign bus.timeout  = timeout_r;

endmodule
`default_nettype wire

// File: tb/tb_ob_ram_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ob_ram_write_arbiter
// Purpose : Self-checking bench for ob_ram_write_arbiter. Directed scenarios
//           plus a randomized multi-book run checked against a burst-level
//           model (ring-order pick, address = book*20 + slot).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ob_ram_write_arbiter;
  import ob_ram_write_arbiter_pkg::*;

  localparam int NB   = 4;
  localparam int DW   = 128;
  localparam int SW   = 5;
  localparam int AW   = 10;
  localparam int BS   = 20;
  localparam int TCYC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ob_ram_write_arbiter_if #(.N_BOOKS(NB), .DATA_W(DW), .SLOT_W(SW), .ADDR_W(AW)) bus ();

  ob_ram_write_arbiter #(
    .N_BOOKS(NB), .DATA_W(DW), .SLOT_W(SW), .BOOK_SLOTS(BS), .ADDR_W(AW), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bus.wr_en   = '0;
    bus.wr_last = '0;
    bus.wr_slot = '0;
    bus.wr_data = '0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_beat(input int b, input int slot, input logic [DW-1:0] d, input bit last);
    bus.wr_en[b]               = 1'b1;
    bus.wr_last[b]             = last;
    bus.wr_slot[b*SW +: SW]    = SW'(slot);
    bus.wr_data[b*DW +: DW]    = d;
  endtask

  // Random beats on every lane except the owner's.
  task automatic noise(input int owner_b);
    for (int b = 0; b < NB; b++) begin
      if (b != owner_b) begin
        bus.wr_en[b]            = 1'($urandom);
        bus.wr_last[b]          = 1'($urandom);
        bus.wr_slot[b*SW +: SW] = SW'($urandom);
        bus.wr_data[b*DW +: DW] = rand_data();
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    clear_beats();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Ring-order rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NB-1:0] mask, input int p);
    for (int k = 0; k < NB; k++) begin
      if (mask[(p + k) % NB]) return (p + k) % NB;
    end
    return -1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst     = 1'b1;
    bus.req = '1;
    noise(-1);
    repeat (3) tick();
    total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", bus.ram_wren); end
    total++; if (bus.ram_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr); end
    total++; if (bus.ram_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.ram_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.slot_err !== 1'b0) begin bad++; $display("FAIL reset_slot_err: got %b want 0", bus.slot_err); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    rst     = 1'b0;
    bus.req = '0;
    clear_beats();
    tick();
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d;
    do_reset();
    bus.req = 4'b0010;
    tick();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL burst_grant: got %b want 0010", bus.grant); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL burst_busy: got %b want 1", bus.busy); end
    for (int s = 0; s < BS; s++) begin
      clear_beats();
      noise(1);
      d = rand_data();
      set_beat(1, s, d, s == BS - 1);
      tick();
      total++; if (bus.ram_wren !== 1'b1 || bus.ram_addr !== AW'(BS + s) || bus.ram_data !== d) begin
        bad++; $display("FAIL burst_beat%0d: got wren=%b addr=%0d data=%h want wren=1 addr=%0d data=%h",
                        s, bus.ram_wren, bus.ram_addr, bus.ram_data, BS + s, d);
      end
      if (s == BS - 1) begin
        total++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL burst_release: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); end
      end else if (s == 10) begin
        total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL burst_hold: got %b want 0010", bus.grant); end
      end
    end
    clear_beats();
    bus.req = '0;
    tick();
    total++; if (bus.ram_wren !== 1'b0 || bus.grant !== 4'b0) begin bad++; $display("FAIL burst_after: got wren=%b grant=%b want 0/0000", bus.ram_wren, bus.grant); end
  endtask

  task automatic test_two_requests();
    logic [DW-1:0] d;
    int s;
    do_reset();
    bus.req = 4'b0101;
    tick();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL two_first: got %b want 0001", bus.grant); end
    d = rand_data(); s = $urandom_range(0, BS - 1);
    set_beat(0, s, d, 1'b1);
    tick();
    total++; if (bus.ram_wren !== 1'b1 || bus.ram_addr !== AW'(s) || bus.grant !== 4'b0) begin
      bad++; $display("FAIL two_last: got wren=%b addr=%0d grant=%b want 1/%0d/0000", bus.ram_wren, bus.ram_addr, bus.grant, s);
    end
    clear_beats();
    bus.req = 4'b0100;
    tick();
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL two_second: got %b want 0100", bus.grant); end
    d = rand_data(); s = $urandom_range(0, BS - 1);
    set_beat(2, s, d, 1'b1);
    tick();
    total++; if (bus.ram_addr !== AW'(2 * BS + s) || bus.ram_data !== d) begin
      bad++; $display("FAIL two_second_addr: got %0d want %0d", bus.ram_addr, 2 * BS + s);
    end
    clear_beats();
    bus.req = '0;
    tick();
  endtask

  task automatic test_all_books();
    logic [DW-1:0] d;
    int s, exp, mptr;
    do_reset();
    mptr = 0;
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      exp = rr_pick(4'b1111, mptr);
      total++; if (bus.grant !== NB'(1 << exp) || exp != r % NB) begin bad++; $display("FAIL rr_round%0d: got %b want book %0d", r, bus.grant, r % NB); end
      d = rand_data(); s = $urandom_range(0, BS - 1);
      noise(exp);
      set_beat(exp, s, d, 1'b1);
      tick();
      total++; if (bus.ram_wren !== 1'b1 || bus.ram_addr !== AW'(exp * BS + s) || bus.grant !== 4'b0) begin
        bad++; $display("FAIL rr_write%0d: got wren=%b addr=%0d grant=%b want 1/%0d/0000", r, bus.ram_wren, bus.ram_addr, bus.grant, exp * BS + s);
      end
      clear_beats();
      mptr = (exp + 1) % NB;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_slot_error();
    logic [DW-1:0] d;
    do_reset();
    bus.req = 4'b1000;
    tick();
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL slot_grant: got %b want 1000", bus.grant); end
    set_beat(3, 25, rand_data(), 1'b0);
    tick();
    total++; if (bus.ram_wren !== 1'b0 || bus.slot_err !== 1'b1 || bus.grant !== 4'b1000) begin
      bad++; $display("FAIL slot_bad: got wren=%b err=%b grant=%b want 0/1/1000", bus.ram_wren, bus.slot_err, bus.grant);
    end
    clear_beats();
    d = rand_data();
    set_beat(3, 5, d, 1'b1);
    tick();
    total++; if (bus.ram_wren !== 1'b1 || bus.ram_addr !== AW'(65) || bus.ram_data !== d || bus.slot_err !== 1'b0) begin
      bad++; $display("FAIL slot_good: got wren=%b addr=%0d err=%b want 1/65/0", bus.ram_wren, bus.ram_addr, bus.slot_err);
    end
    clear_beats();
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0001;
    tick();
    set_beat(0, 3, rand_data(), 1'b1);
    tick();
    clear_beats();
    bus.req = 4'b0100;
    tick();
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL rstmid_grant: got %b want 0100", bus.grant); end
    for (int b = 0; b < 7; b++) begin
      clear_beats();
      set_beat(2, b, rand_data(), 1'b0);
      tick();
    end
    clear_beats();
    set_beat(2, 7, rand_data(), 1'b0);
    rst = 1'b1;
    tick();
    total++; if (bus.grant !== 4'b0 || bus.ram_wren !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop: got grant=%b wren=%b busy=%b want 0000/0/0", bus.grant, bus.ram_wren, bus.busy);
    end
    rst = 1'b0;
    clear_beats();
    bus.req = 4'b0101;
    tick();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rstmid_ptr: got %b want 0001", bus.grant); end
    set_beat(0, 0, rand_data(), 1'b1);
    tick();
    clear_beats();
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [NB-1:0] pend;
    logic [DW-1:0] d;
    int mptr, exp, len, s;
    do_reset();
    mptr = 0;
    pend = NB'($urandom);
    if (pend == '0) pend = 4'b0001;
    for (int r = 0; r < 40; r++) begin
      bus.req = pend;
      clear_beats();
      tick();
      exp = rr_pick(pend, mptr);
      total++; if (bus.grant !== NB'(1 << exp)) begin bad++; $display("FAIL rand_grant%0d: got %b want book %0d (req %b)", r, bus.grant, exp, pend); end
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        clear_beats();
        noise(exp);
        s = ($urandom_range(0, 7) == 0) ? $urandom_range(BS, 31) : $urandom_range(0, BS - 1);
        d = rand_data();
        set_beat(exp, s, d, b == len - 1);
        tick();
        if (s < BS) begin
          total++; if (bus.ram_wren !== 1'b1 || bus.ram_addr !== AW'(exp * BS + s) || bus.ram_data !== d || bus.slot_err !== 1'b0) begin
            bad++; $display("FAIL rand_write%0d_%0d: got wren=%b addr=%0d err=%b want 1/%0d/0", r, b, bus.ram_wren, bus.ram_addr, bus.slot_err, exp * BS + s);
          end
        end else begin
          total++; if (bus.ram_wren !== 1'b0 || bus.slot_err !== 1'b1) begin
            bad++; $display("FAIL rand_slot%0d_%0d: got wren=%b err=%b want 0/1", r, b, bus.ram_wren, bus.slot_err);
          end
        end
        total++; if (bus.grant !== ((b == len - 1) ? NB'(0) : NB'(1 << exp))) begin
          bad++; $display("FAIL rand_hold%0d_%0d: got %b (book %0d, last=%0d)", r, b, bus.grant, exp, b == len - 1);
        end
      end
      pend = pend & ~NB'(1 << exp);
      pend = pend | NB'($urandom);
      if (pend == '0) pend = NB'(1 << $urandom_range(0, NB - 1));
      mptr = (exp + 1) % NB;
    end
    clear_beats();
    bus.req = '0;
    tick();
    tick();
  endtask

`ifdef OB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0110;
    tick();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL tmo_grant: got %b want 0010", bus.grant); end
    for (int i = 1; i < TCYC; i++) begin
      tick();
      if (i == TCYC - 1) begin
        total++; if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0) begin
          bad++; $display("FAIL tmo_early: got grant=%b timeout=%b want 0010/0", bus.grant, bus.timeout);
        end
      end
    end
    tick();
    total++; if (bus.grant !== 4'b0 || bus.timeout !== 1'b1) begin
      bad++; $display("FAIL tmo_fire: got grant=%b timeout=%b want 0000/1", bus.grant, bus.timeout);
    end
    bus.req = 4'b0100;
    tick();
    total++; if (bus.grant !== 4'b0100 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_next: got grant=%b timeout=%b want 0100/0", bus.grant, bus.timeout);
    end
    bus.req = '0;
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    bus.req = 4'b0110;
    tick();
    for (int i = 0; i < TCYC + 16; i++) begin
      tick();
      if (bus.timeout !== 1'b0) begin
        total++; bad++; $display("FAIL notmo_pulse: got timeout=%b want 0 at idle cycle %0d", bus.timeout, i);
      end
    end
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL notmo_hold: got %b want 0010", bus.grant); end
    bus.req = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    clear_beats();
    test_reset();
    test_single_burst();
    test_two_requests();
    test_all_books();
    test_slot_error();
    test_reset_mid_burst();
    test_random();
`ifdef OB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
